inst_fetch_unit: RTL and testbench

Instruction fetch stage that produces `{pc, instruction}` packets for the one-deep front-end buffer feeding decode. It owns the fetch PC and issues single-outstanding requests on a request/grant/response instruction-memory port. It writes each returned instruction into the downstream buffer and redirects on `JumpFlag`, discarding any stale in-flight or held instruction.

---
 rtl/inst_fetch_unit_if.sv | 22 ++
 rtl/inst_fetch_unit.sv | 74 +++++++
 tb/tb_inst_fetch_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: instruction-memory request/grant/response port plus front-end buffer write port
interface inst_fetch_unit_if #(
    parameter int AddrWidth = 64,
    parameter int InstWidth = 32
) ();
    logic                           ireq;
    logic [AddrWidth-1:0]           iaddr;
    logic                           ignt;
    logic                           irvalid;
    logic [InstWidth-1:0]           irdata;
    logic                           fifo_winc;
    logic [AddrWidth+InstWidth-1:0] fifo_wdata;
    logic                           fifo_wfull;
    modport master (
        output ireq, iaddr, fifo_winc, fifo_wdata,
        input  ignt, irvalid, irdata, fifo_wfull
    );
    modport slave (
        input  ireq, iaddr, fifo_winc, fifo_wdata,
        output ignt, irvalid, irdata, fifo_wfull
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: single-outstanding instruction fetch producing {pc, inst} packets for decode
module inst_fetch_unit #(
    parameter int                   AddrWidth = 64,
    parameter int                   InstWidth = 32,
    parameter logic [AddrWidth-1:0] ResetPc   = 64'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 jump_flag,
    input  logic [AddrWidth-1:0] jump_addr,
    inst_fetch_unit_if.master    bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
    state_t               state;
    logic [AddrWidth-1:0] pc;
    logic [InstWidth-1:0] hold_inst;
    logic                 drop;
    logic                 req;
    logic [AddrWidth-1:0] tgt;
    assign tgt = jump_addr & ~AddrWidth'(3);
    assign bus.ireq = req;
    assign bus.iaddr = pc;
    assign bus.fifo_winc = (state == HOLD) && !bus.fifo_wfull && !jump_flag;
    assign bus.fifo_wdata = (state == HOLD) ? {pc, hold_inst} : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= ResetPc;
            hold_inst <= '0;
            drop      <= 1'b0;
            req       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    req   <= 1'b1;
                    if (jump_flag) pc <= tgt;
                end
                REQ: if (jump_flag) begin
                    pc    <= tgt;
                    drop  <= bus.ignt;
                    req   <= 1'b0;
                    state <= bus.ignt ? WAIT : IDLE;
                end else if (bus.ignt) begin
                    state <= WAIT;
                    req   <= 1'b0;
                end
                // a jump without the response leaves drop set so the late response is discarded
                WAIT: if (jump_flag) begin
                    pc   <= tgt;
                    drop <= !bus.irvalid;
                    if (bus.irvalid) begin
                        state <= REQ;
                        req   <= 1'b1;
                    end
                end else if (bus.irvalid) begin
                    if (!drop) hold_inst <= bus.irdata;
                    drop  <= 1'b0;
                    state <= drop ? REQ : HOLD;
                    req   <= drop;
                end
                HOLD: if (jump_flag || !bus.fifo_wfull) begin
                    pc    <= jump_flag ? tgt : pc + AddrWidth'(4);
                    state <= REQ;
                    req   <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed scenarios followed by random memory/back-pressure/jump traffic
module tb_inst_fetch_unit;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag = 1'b0;
    logic [63:0] jump_addr = '0;
    int          tests = 0;
    int          failed = 0;
    inst_fetch_unit_if #(.AddrWidth(64), .InstWidth(32)) bus ();
    inst_fetch_unit #(.AddrWidth(64), .InstWidth(32), .ResetPc(RESET_PC)) dut (
        .clk(clk), .rst(rst), .jump_flag(jump_flag), .jump_addr(jump_addr), .bus(bus)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic grant_and_return(input logic [31:0] data);
        bus.ignt = 1'b1;
        tick();
        bus.ignt = 1'b0;
        bus.irvalid = 1'b1;
        bus.irdata = data;
        tick();
        bus.irvalid = 1'b0;
    endtask
    initial begin
        logic [63:0] exp_pc;
        logic [63:0] maddr;
        logic [63:0] stall_addr;
        logic        busy;
        logic        stall;
        logic        prev_jump;
        int          lat;
        int          writes;
        bus.ignt = 1'b0;
        bus.irvalid = 1'b0;
        bus.irdata = '0;
        bus.fifo_wfull = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_ireq", bus.ireq, 0);
        chk("reset_iaddr", bus.iaddr, RESET_PC);
        chk("reset_winc", bus.fifo_winc, 0);
        chk("reset_wdata", bus.fifo_wdata, 0);
        rst = 1'b0;
        tick();
        #1 chk("boot_ireq", bus.ireq, 1);
        chk("boot_iaddr", bus.iaddr, RESET_PC);
        grant_and_return(32'h0000_0013);
        #1 chk("boot_winc", bus.fifo_winc, 1);
        chk("boot_wdata", bus.fifo_wdata, {RESET_PC, 32'h0000_0013});
        tick();
        #1 chk("boot_next_iaddr", bus.iaddr, 64'h8000_0004);
        bus.ignt = 1'b1;
        tick();
        bus.ignt = 1'b0;
        bus.irvalid = 1'b1;
        bus.irdata = 32'hDEAD_BEEF;
        bus.fifo_wfull = 1'b1;
        tick();
        bus.irvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_winc", bus.fifo_winc, 0);
            chk("bp_ireq", bus.ireq, 0);
            tick();
        end
        bus.fifo_wfull = 1'b0;
        #1 chk("bp_release_winc", bus.fifo_winc, 1);
        chk("bp_release_wdata", bus.fifo_wdata, {64'h8000_0004, 32'hDEAD_BEEF});
        tick();
        #1 chk("bp_single_write", bus.fifo_winc, 0);
        chk("bp_next_iaddr", {bus.ireq, bus.iaddr}, {1'b1, 64'h8000_0008});
        bus.ignt = 1'b1;
        tick();
        bus.ignt = 1'b0;
        jump_flag = 1'b1;
        jump_addr = 64'h8000_0103;
        tick();
        jump_flag = 1'b0;
        bus.irvalid = 1'b1;
        bus.irdata = 32'hBAD0_0001;
        tick();
        bus.irvalid = 1'b0;
        #1 chk("jwait_winc", bus.fifo_winc, 0);
        chk("jwait_iaddr", {bus.ireq, bus.iaddr}, {1'b1, 64'h8000_0100});
        bus.ignt = 1'b1;
        jump_flag = 1'b1;
        jump_addr = 64'h8000_0200;
        tick();
        bus.ignt = 1'b0;
        jump_flag = 1'b0;
        bus.irvalid = 1'b1;
        bus.irdata = 32'hBAD0_0002;
        tick();
        bus.irvalid = 1'b0;
        #1 chk("jgnt_winc", bus.fifo_winc, 0);
        chk("jgnt_iaddr", {bus.ireq, bus.iaddr}, {1'b1, 64'h8000_0200});
        bus.ignt = 1'b1;
        tick();
        bus.ignt = 1'b0;
        bus.irvalid = 1'b1;
        bus.irdata = 32'hBAD0_0003;
        jump_flag = 1'b1;
        jump_addr = 64'h8000_0300;
        tick();
        bus.irvalid = 1'b0;
        jump_flag = 1'b0;
        #1 chk("jvalid_winc", bus.fifo_winc, 0);
        chk("jvalid_iaddr", {bus.ireq, bus.iaddr}, {1'b1, 64'h8000_0300});
        grant_and_return(32'h1234_5678);
        #1 chk("jvalid_fetch_wdata", {bus.fifo_winc, bus.fifo_wdata}, {1'b1, 64'h8000_0300, 32'h1234_5678});
        jump_flag = 1'b1;
        jump_addr = 64'h8000_0400;
        #1 chk("jhold_winc", bus.fifo_winc, 0);
        tick();
        jump_flag = 1'b0;
        #1 chk("jhold_iaddr", {bus.ireq, bus.iaddr}, {1'b1, 64'h8000_0400});
        jump_flag = 1'b1;
        jump_addr = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        jump_flag = 1'b0;
        #1 chk("jreq_withdraw", bus.ireq, 0);
        tick();
        #1 chk("jreq_iaddr", {bus.ireq, bus.iaddr}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFC});
        grant_and_return(32'h0BAD_F00D);
        #1 chk("wrap_wdata", {bus.fifo_winc, bus.fifo_wdata}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0BAD_F00D});
        tick();
        #1 chk("wrap_iaddr", {bus.ireq, bus.iaddr}, {1'b1, 64'h0});
        bus.ignt = 1'b1;
        tick();
        bus.ignt = 1'b0;
        #3 rst = 1'b1;
        #1 chk("async_rst_ireq", bus.ireq, 0);
        chk("async_rst_iaddr", bus.iaddr, RESET_PC);
        chk("async_rst_out", {bus.fifo_winc, bus.fifo_wdata}, 0);
        tick();
        rst = 1'b0;
        exp_pc = RESET_PC;
        busy = 1'b0;
        stall = 1'b0;
        prev_jump = 1'b0;
        maddr = '0;
        stall_addr = '0;
        lat = 0;
        writes = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.irvalid = busy && (lat == 0);
            bus.irdata = bus.irvalid ? mem_word(maddr) : $urandom;
            bus.ignt = bus.ireq && ($urandom_range(2) != 0);
            jump_flag = !prev_jump && ($urandom_range(14) == 0);
            jump_addr = ($urandom_range(3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15)))
                                                 : {$urandom, $urandom};
            bus.fifo_wfull = ($urandom_range(2) == 0);
            #1;
            if (bus.ireq) chk("one_outstanding", busy, 0);
            chk("iaddr_align", bus.iaddr[1:0], 0);
            if (stall) chk("iaddr_stable", {bus.ireq, bus.iaddr}, {1'b1, stall_addr});
            if (bus.fifo_winc) begin
                chk("write_legal", bus.fifo_wfull || jump_flag, 0);
                chk("write_packet", bus.fifo_wdata, {exp_pc, mem_word(exp_pc)});
                exp_pc = exp_pc + 64'd4;
                writes++;
            end
            if (jump_flag) exp_pc = jump_addr & ~64'h3;
            if (bus.irvalid) busy = 1'b0;
            else if (busy) lat--;
            if (bus.ignt) begin
                busy = 1'b1;
                maddr = bus.iaddr;
                lat = $urandom_range(2);
            end
            stall = bus.ireq && !bus.ignt && !jump_flag;
            stall_addr = bus.iaddr;
            prev_jump = jump_flag;
            tick();
        end
        jump_flag = 1'b0;
        bus.ignt = 1'b0;
        bus.irvalid = 1'b0;
        chk("random_progress", writes > 50, 1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
